// File: rtl/alu_seq.sv
// alu_seq: request/response ALU with compare flags and an optional
// iterative multiply/divide unit enabled by defining ALU_SEQ_MULDIV_EN.
package isa_types_pkg;
    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA,
        SLT, SLTU, LT, GE, LTU, GEU, EQ, NE,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } operator_t;
endpackage

module alu_seq
    import isa_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  operator_t       opcode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zeros,
    output logic            ltu,
    output logic            lt
);

    localparam int SW = $clog2(XLEN);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zeros;
    logic            r_lt;
    logic            r_ltu;

    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] w_acc_res;
    logic            w_zeros;
    logic            w_lt;
    logic            w_ltu;
    logic            w_slt;
    logic [SW-1:0]   w_sh;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zeros     = r_zeros;
    assign lt        = r_lt;
    assign ltu       = r_ltu;

    // Compare ops leave result at zero; everything else leaves flags at zero.
    always_comb begin
        w_sh    = B[SW-1:0];
        w_slt   = $signed(A) < $signed(B);
        w_res   = '0;
        w_zeros = 1'b0;
        w_lt    = 1'b0;
        w_ltu   = 1'b0;
        case (opcode)
            ADD:       w_res = A + B;
            SUB:       w_res = A - B;
            AND:       w_res = A & B;
            OR:        w_res = A | B;
            XOR:       w_res = A ^ B;
            SLL:       w_res = A << w_sh;
            SRL:       w_res = A >> w_sh;
            SRA:       w_res = $signed(A) >>> w_sh;
            SLT, LT:   w_lt = w_slt;
            GE:        w_lt = !w_slt;
            SLTU, LTU: w_ltu = A < B;
            GEU:       w_ltu = A >= B;
            EQ:        w_zeros = A == B;
            NE:        w_zeros = A != B;
            default:   w_res = A + B;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    operator_t         r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opd;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [SW-1:0]     r_cnt;

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_iter;
    logic              w_div_it;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shl;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_md_res;

    // Signed operands are iterated as magnitudes; signs are fixed up at the end.
    always_comb begin
        w_is_mul = opcode inside {MUL, MULH, MULHSU, MULHU};
        w_is_div = opcode inside {DIV, DIVU, REM, REMU};
        w_a_sgn  = A[XLEN-1] && (opcode inside {MULH, MULHSU, DIV, REM});
        w_b_sgn  = B[XLEN-1] && (opcode inside {MULH, DIV, REM});
        w_a_mag  = w_a_sgn ? -A : A;
        w_b_mag  = w_b_sgn ? -B : B;
        w_div0   = w_is_div && (B == '0);
        w_ovf    = (opcode inside {DIV, REM}) &&
                   (A == MOST_NEG) && (B == '1);
        w_iter   = (w_is_mul || w_is_div) && !w_div0 && !w_ovf;
    end

    always_comb begin
        w_acc_res = w_res;
        if (w_div0)
            w_acc_res = (opcode inside {DIV, DIVU}) ? '1 : A;
        else if (w_ovf)
            w_acc_res = (opcode == DIV) ? A : '0;
    end

    always_comb begin
        w_div_it = r_op inside {DIV, DIVU, REM, REMU};
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
        w_shl    = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_shl - {1'b0, r_opd};
        if (w_div_it) begin
            w_hi_nx = w_diff[XLEN] ? w_shl[XLEN-1:0] : w_diff[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], !w_diff[XLEN]};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod_s = r_neg_q ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
        w_quo    = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_rem    = r_neg_r ? -w_hi_nx : w_hi_nx;
        case (r_op)
            MUL:                 w_md_res = w_prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: w_md_res = w_prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           w_md_res = w_quo;
            default:             w_md_res = w_rem;
        endcase
    end
`else
    assign w_acc_res = w_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zeros     <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_op        <= ADD;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opd       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
`endif
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (w_iter) begin
                            r_state <= BUSY;
                            r_op    <= opcode;
                            r_cnt   <= '0;
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                            r_opd   <= w_is_div ? w_b_mag : w_a_mag;
                            r_neg_q <= w_a_sgn ^ w_b_sgn;
                            r_neg_r <= w_a_sgn;
                        end else
`endif
                        begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_acc_res;
                            r_zeros     <= w_zeros;
                            r_lt        <= w_lt;
                            r_ltu       <= w_ltu;
                        end
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                BUSY: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_res;
                        r_zeros     <= 1'b0;
                        r_lt        <= 1'b0;
                        r_ltu       <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table for alu_seq plus handshake,
// flush and reset sequences; muldiv expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
    import isa_types_pkg::*;

    localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
    localparam int MDL = XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    operator_t       opcode;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zeros;
    logic            ltu;
    logic            lt;

    int checks = 0;
    int failures = 0;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zeros     (zeros),
        .ltu       (ltu),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        operator_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input operator_t op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        lat = out_valid ? n : -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = ADD;
        A         = '0;
        B         = '0;
        tick();
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", {zeros, lt, ltu}, 0);
        rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);

        vt.push_back('{ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b000, 1});
        vt.push_back('{SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 3'b000, 1});
        vt.push_back('{AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 3'b000, 1});
        vt.push_back('{OR, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 3'b000, 1});
        vt.push_back('{XOR, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 3'b000, 1});
        vt.push_back('{SLL, 32'h1, 32'h3F, 32'h80000000, 3'b000, 1});
        vt.push_back('{SRL, 32'h80000000, 32'h4, 32'h08000000, 3'b000, 1});
        vt.push_back('{SRA, 32'h80000000, 32'h4, 32'hF8000000, 3'b000, 1});
        vt.push_back('{SRA, 32'h80000000, 32'h20, 32'h80000000, 3'b000, 1});
        vt.push_back('{SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b010, 1});
        vt.push_back('{LT, 32'h1, 32'hFFFFFFFF, 32'h0, 3'b000, 1});
        vt.push_back('{GE, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b000, 1});
        vt.push_back('{GE, 32'h1, 32'hFFFFFFFF, 32'h0, 3'b010, 1});
        vt.push_back('{GEU, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b001, 1});
        vt.push_back('{SLTU, 32'h1, 32'hFFFFFFFF, 32'h0, 3'b001, 1});
        vt.push_back('{LTU, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b000, 1});
        vt.push_back('{EQ, 32'd5, 32'd5, 32'h0, 3'b100, 1});
        vt.push_back('{EQ, 32'd5, 32'd6, 32'h0, 3'b000, 1});
        vt.push_back('{NE, 32'd5, 32'd5, 32'h0, 3'b000, 1});
        vt.push_back('{NE, 32'd5, 32'd6, 32'h0, 3'b100, 1});
        vt.push_back('{operator_t'(5'd31), 32'd3, 32'd4, 32'd7, 3'b000, 1});
`ifdef ALU_SEQ_MULDIV_EN
        vt.push_back('{MULH, 32'h80000000, 32'h80000000, 32'h40000000, 3'b000, MDL});
        vt.push_back('{MULHU, 32'h80000000, 32'h80000000, 32'h40000000, 3'b000, MDL});
        vt.push_back('{MUL, 32'h80000000, 32'h80000000, 32'h0, 3'b000, MDL});
        vt.push_back('{MUL, 32'd12345, 32'd1000, 32'h00BC5EA8, 3'b000, MDL});
        vt.push_back('{MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3'b000, MDL});
        vt.push_back('{MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 3'b000, MDL});
        vt.push_back('{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, MDL});
        vt.push_back('{MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3'b000, MDL});
        vt.push_back('{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b000, 1});
        vt.push_back('{REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 3'b000, 1});
        vt.push_back('{DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 3'b000, 1});
        vt.push_back('{REMU, 32'd7, 32'd0, 32'd7, 3'b000, 1});
        vt.push_back('{DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 3'b000, 1});
        vt.push_back('{REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 3'b000, 1});
        vt.push_back('{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 3'b000, MDL});
        vt.push_back('{DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 3'b000, MDL});
        vt.push_back('{REM, 32'd7, 32'hFFFFFFFE, 32'd1, 3'b000, MDL});
        vt.push_back('{DIV, 32'h80000000, 32'd2, 32'hC0000000, 3'b000, MDL});
        vt.push_back('{DIVU, 32'd100, 32'd7, 32'd14, 3'b000, MDL});
        vt.push_back('{REMU, 32'd100, 32'd7, 32'd2, 3'b000, MDL});
        vt.push_back('{REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 3'b000, MDL});
`else
        vt.push_back('{MUL, 32'd3, 32'd4, 32'd7, 3'b000, 1});
        vt.push_back('{DIVU, 32'd7, 32'd0, 32'd7, 3'b000, 1});
        vt.push_back('{REMU, 32'd5, 32'd6, 32'd11, 3'b000, 1});
`endif

        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, lat);
            chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d result", i), result, vt[i].res);
            chk($sformatf("vec%0d flags", i), {zeros, lt, ltu}, vt[i].flg);
            release_out();
        end

        // Result must stay put while the consumer stalls.
`ifdef ALU_SEQ_MULDIV_EN
        issue(DIV, 32'hFFFFFFF9, 32'd2, lat);
        chk("hold latency", lat, MDL);
`else
        issue(SUB, 32'd2, 32'd5, lat);
        chk("hold latency", lat, 1);
`endif
        opcode   = ADD;
        A        = 32'd1;
        B        = 32'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d result", k), result, 32'hFFFFFFFD);
            chk($sformatf("hold%0d out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d in_ready", k), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold release out_valid", out_valid, 0);
        chk("hold release in_ready", in_ready, 1);
        chk("hold release result", result, 32'hFFFFFFFD);

        opcode   = ADD;
        A        = 32'd9;
        B        = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush-vs-accept out_valid", out_valid, 0);
        chk("flush-vs-accept in_ready", in_ready, 1);
        chk("flush-vs-accept result", result, 32'hFFFFFFFD);

`ifdef ALU_SEQ_MULDIV_EN
        opcode   = DIVU;
        A        = 32'd100;
        B        = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("busy in_ready", in_ready, 0);
`else
        opcode   = ADD;
        A        = 32'd2;
        B        = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("done before flush", out_valid, 1);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush in_ready", in_ready, 1);
        chk("flush out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= out_valid;
        end
        chk("flush no result", seen, 0);

`ifdef ALU_SEQ_MULDIV_EN
        opcode   = DIVU;
        A        = 32'd100;
        B        = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
`else
        opcode   = ADD;
        A        = 32'd2;
        B        = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("done before rst", result, 32'd5);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst result", result, 0);
        chk("async rst flags", {zeros, lt, ltu}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post rst in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= out_valid;
        end
        chk("post rst no result", seen, 0);

        issue(ADD, 32'h7FFFFFFF, 32'h1, lat);
        chk("post rst latency", lat, 1);
        chk("post rst result", result, 32'h80000000);
        release_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
